mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning the memory read-data latency in cycles after the mem_cen cycle (legal range 1..7).
REQ-002 SHALL have parameter AW, default 27, meaning the memory byte-address width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk, input, 1, rising-edge clock; rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ifu_req, input, 1, instruction fetch request.
REQ-005 SHALL have port ifu_addr, input, AW, fetch byte address.
REQ-006 SHALL have port ifu_gnt, output, 1, fetch accepted this cycle.
REQ-007 SHALL have port ifu_rvalid, output, 1, fetch data valid.
REQ-008 SHALL have port ifu_rdata, output, 32, fetched instruction.
REQ-009 SHALL have port lsu_req, input, 1, data access request.
REQ-010 SHALL have port lsu_wr, input, 1, 1=write, 0=read.
REQ-011 SHALL have ports lsu_strb (input, 8, byte strobes), lsu_addr (input, AW, byte address) and lsu_wdata (input, 64, write data).
REQ-012 SHALL have port lsu_gnt, output, 1, data access accepted this cycle.
REQ-013 SHALL have port lsu_rvalid, output, 1, read data valid, or write completion.
REQ-014 SHALL have ports lsu_rdata (output, 64, read data) and lsu_error (output, 1, error response).
REQ-015 SHALL have ports mem_cen (output, 1), mem_wr (output, 1), mem_strb (output, 8), mem_addr (output, AW) and mem_wdata (output, 64), forming the shared memory command.
REQ-016 SHALL have ports mem_rdata (input, 64, read data) and mem_error (input, 1, sampled with mem_rdata).

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP, with at most one outstanding memory access.
REQ-018 In IDLE, with any request present, SHALL grant exactly one requester, drive mem_cen=1 with that requester's command in the same cycle (combinational grant), and go to WAIT.
REQ-019 On simultaneous ifu_req and lsu_req, SHALL grant the requester not granted last; after reset, last_gnt SHALL equal IFU, so the LSU wins the first tie.
REQ-020 With a single requester present, SHALL grant it regardless of last_gnt, and SHALL update last_gnt on every grant.
REQ-021 An IFU grant SHALL drive mem_wr=0, mem_strb=8'hFF, mem_addr={ifu_addr[AW-1:3],3'b0}, and SHALL register ifu_addr[2].
REQ-022 An LSU grant SHALL pass lsu_wr, lsu_strb, lsu_addr and lsu_wdata unchanged.
REQ-023 WAIT SHALL count cycles from 1; when the count reaches RD_LAT, it SHALL capture mem_rdata and mem_error into a response register and go to RESP.
REQ-024 RESP SHALL assert exactly one cycle of the owner's rvalid, then return to IDLE.
REQ-025 New grants SHALL be issued in IDLE only; back-to-back throughput is therefore one access per RD_LAT+2 cycles.
REQ-026 ifu_rdata SHALL be captured_data[63:32] if the registered addr[2]=1, else captured_data[31:0].
REQ-027 lsu_rdata SHALL be the full 64-bit captured data; lsu_error SHALL equal the captured mem_error and be valid only with lsu_rvalid.
REQ-028 An error on an IFU access SHALL be dropped; ifu_rvalid SHALL still assert.
REQ-029 For an LSU write, lsu_rvalid SHALL assert in RESP as the completion signal, with lsu_rdata don't-care.
REQ-030 Outside IDLE, mem_cen, ifu_gnt and lsu_gnt SHALL be 0, and requests SHALL be held by requesters (not lost).
REQ-031 rvalid outputs SHALL be 0 outside RESP; rdata outputs SHALL hold their last captured value.
REQ-032 A requester deasserting req before its grant SHALL be legal; the arbiter SHALL hold no state for ungranted requests.

Reset
REQ-033 rstn=0 SHALL asynchronously force: state=IDLE, wait counter=0, last_gnt=IFU, captured data=0, captured error=0, owner=IFU, and registered addr[2]=0.
REQ-034 During reset, all outputs SHALL be 0; combinational grant SHALL be suppressed while rstn=0.
REQ-035 Reset asserted in WAIT or RESP SHALL abandon the access with no rvalid; the first grant after release SHALL follow REQ-019.

Verification
REQ-036 Reset then ifu_req=1, ifu_addr=0x0000004, mem_rdata=64'h11112222_33334444, RD_LAT=1 -> ifu_gnt and mem_cen in cycle 0, mem_addr=0; ifu_rvalid in cycle 2 with ifu_rdata=32'h11112222.
REQ-037 Both requests held continuously after reset -> grant order LSU, IFU, LSU, IFU, with grants 3 cycles apart.
REQ-038 LSU write with lsu_strb=8'h0F, addr 0x10, wdata 64'hA5 -> mem_wr=1, mem_strb=8'h0F, mem_wdata=64'hA5 in the grant cycle; lsu_rvalid=1 exactly one cycle at RD_LAT+1.
REQ-039 LSU read with mem_error=1 at capture -> lsu_rvalid=1 with lsu_error=1; the same on an IFU access -> ifu_rvalid=1 and no error output.
REQ-040 rstn pulsed low during WAIT -> outputs 0 immediately, no rvalid follows; a held lsu_req is granted on the first cycle after release.
REQ-041 RD_LAT=3 single LSU read -> lsu_rvalid exactly 4 cycles after lsu_gnt, and mem_cen low for 4 cycles after the grant.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port (fetch / load-store) arbiter onto a single fixed-latency memory port.
// One access in flight at a time; round-robin on ties, combinational grant in idle.
module mem_arb #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 27
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ifu_req,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_gnt,
  output logic          ifu_rvalid,
  output logic [31:0]   ifu_rdata,
  input  logic          lsu_req,
  input  logic          lsu_wr,
  input  logic [7:0]    lsu_strb,
  input  logic [AW-1:0] lsu_addr,
  input  logic [63:0]   lsu_wdata,
  output logic          lsu_gnt,
  output logic          lsu_rvalid,
  output logic [63:0]   lsu_rdata,
  output logic          lsu_error,
  output logic          mem_cen,
  output logic          mem_wr,
  output logic [7:0]    mem_strb,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,
  input  logic          mem_error
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [2:0]    LatCnt   = 3'(RD_LAT);
  localparam logic [AW-1:0] AddrMask = ~(AW'(7));

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_q, last_d;    // 1: LSU was granted last
  logic        owner_q, owner_d;  // 1: LSU owns the outstanding access
  logic        half_q, half_d;    // fetch address bit 2 selects upper word
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;
  logic        pick_lsu;

  // On a tie the LSU wins unless it was the last one served.
  assign pick_lsu = lsu_req & (~ifu_req | ~last_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    half_d     = half_q;
    data_d     = data_q;
    err_d      = err_q;
    ifu_gnt    = 1'b0;
    lsu_gnt    = 1'b0;
    mem_cen    = 1'b0;
    mem_wr     = 1'b0;
    mem_strb   = 8'h00;
    mem_addr   = '0;
    mem_wdata  = '0;
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rstn && (ifu_req || lsu_req)) begin
          mem_cen = 1'b1;
          state_d = StWait;
          cnt_d   = 3'd1;
          owner_d = pick_lsu;
          last_d  = pick_lsu;
          if (pick_lsu) begin
            lsu_gnt   = 1'b1;
            mem_wr    = lsu_wr;
            mem_strb  = lsu_strb;
            mem_addr  = lsu_addr;
            mem_wdata = lsu_wdata;
          end else begin
            ifu_gnt  = 1'b1;
            mem_strb = 8'hFF;
            mem_addr = ifu_addr & AddrMask;
            half_d   = ifu_addr[2];
          end
        end
      end
      StWait: begin
        if (cnt_q == LatCnt) begin
          data_d  = mem_rdata;
          err_d   = mem_error;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StResp: begin
        ifu_rvalid = ~owner_q;
        lsu_rvalid = owner_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      last_q  <= 1'b0;
      owner_q <= 1'b0;
      half_q  <= 1'b0;
      data_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      half_q  <= half_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign ifu_rdata = half_q ? data_q[63:32] : data_q[31:0];
  assign lsu_rdata = data_q;
  assign lsu_error = lsu_rvalid & err_q;

endmodule
